// File: rtl/edge_morph_pkg.sv
// Shared constants, types and helpers for the edge_morph binary morphology stage.
package edge_morph_pkg;

    localparam int unsigned LAT     = 3;
    localparam int unsigned ROW_W   = 11;
    localparam int unsigned ROW_MAX = 2047;

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_ERODE    = 2'b01;
    localparam logic [1:0] MODE_DILATE   = 2'b10;
    localparam logic [1:0] MODE_MAJORITY = 2'b11;

    localparam logic [15:0] FG_565 = 16'h0000;
    localparam logic [15:0] BG_565 = 16'hFFFF;

    localparam logic [3:0] MAJ_THRESH = 4'd5;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) n = n + 4'(bits[i]);
        return n;
    endfunction

endpackage

// File: rtl/edge_morph_if.sv
// Video stream bundle between the Sobel stage, edge_morph and the VGA output mux.
interface edge_morph_if;
    logic [1:0]  iMode;
    logic        iVGA_de;
    logic        iVGA_hs;
    logic        iVGA_vs;
    logic [15:0] iRGB_565;
    logic        oVGA_de;
    logic        oVGA_hs;
    logic        oVGA_vs;
    logic [15:0] oVGA_565;

    modport master (
        output iMode, iVGA_de, iVGA_hs, iVGA_vs, iRGB_565,
        input  oVGA_de, oVGA_hs, oVGA_vs, oVGA_565
    );

    modport slave (
        input  iMode, iVGA_de, iVGA_hs, iVGA_vs, iRGB_565,
        output oVGA_de, oVGA_hs, oVGA_vs, oVGA_565
    );
endinterface

// File: rtl/line_buf_1b.sv
// 1-bit x DEPTH line buffer with registered read; a same-address write returns the old bit.
module line_buf_1b #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_bit,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit
);
    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) rd_bit <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_bit;
    end
endmodule

// File: rtl/edge_morph.sv
// 3x3 binary erode/dilate/majority filter on the Sobel edge map, fixed 3-clock latency.
module edge_morph
    import edge_morph_pkg::*;
#(
    parameter int unsigned H_MAX     = 1024,
    parameter logic        VS_ACTIVE = 1'b1
) (
    input  logic        vga_clk,
    input  logic        rst,
    edge_morph_if.slave vid
);
    localparam int unsigned      COL_W   = $clog2(H_MAX + 1);
    localparam int unsigned      ADDR_W  = $clog2(H_MAX);
    localparam logic [COL_W-1:0] COL_SAT = COL_W'(H_MAX);
    localparam logic [ROW_W-1:0] ROW_SAT = ROW_W'(ROW_MAX);

    logic [COL_W-1:0]  col, s1_col, s2_col;
    logic [ROW_W-1:0]  row, s1_row, s2_row;
    logic              vs_on_q, frame_ok;
    logic [1:0]        mode_r, s1_mode, s2_mode;
    logic              s1_ok, s2_ok, s1_fg;
    logic [15:0]       s1_pix, s2_pix, out_565;
    logic              rd1, rd2;
    logic [2:0][2:0]   win;
    sync_t [LAT-1:0]   sync_d;

    logic              vs_on, vs_edge, lb_en, s1_wr;
    logic [ADDR_W-1:0] addr, s1_addr;
    logic [1:0]        eff_mode;
    sync_t             sync_in;

    // Until the first vs after reset the live mode applies, so bypass works at once
    // while morph modes stay gated by frame_ok.
    always_comb begin
        vs_on    = (vid.iVGA_vs == VS_ACTIVE);
        vs_edge  = vs_on & ~vs_on_q;
        lb_en    = vid.iVGA_de & (col < COL_SAT);
        addr     = ADDR_W'(col);
        s1_wr    = sync_d[0].de & (s1_col < COL_SAT);
        s1_addr  = ADDR_W'(s1_col);
        eff_mode = frame_ok ? mode_r : vid.iMode;
        sync_in  = '{de: vid.iVGA_de, hs: vid.iVGA_hs, vs: vid.iVGA_vs};
    end

    // Row-1 buffer takes the new fg bit; row-2 buffer takes what row-1 held one stage later.
    line_buf_1b #(.DEPTH(H_MAX), .ADDR_W(ADDR_W)) u_lb_row1 (
        .clk     (vga_clk),
        .wr_en   (lb_en),
        .wr_addr (addr),
        .wr_bit  (vid.iRGB_565 == FG_565),
        .rd_en   (lb_en),
        .rd_addr (addr),
        .rd_bit  (rd1)
    );

    line_buf_1b #(.DEPTH(H_MAX), .ADDR_W(ADDR_W)) u_lb_row2 (
        .clk     (vga_clk),
        .wr_en   (s1_wr),
        .wr_addr (s1_addr),
        .wr_bit  (rd1),
        .rd_en   (lb_en),
        .rd_addr (addr),
        .rd_bit  (rd2)
    );

    // Counters, frame state and the stage-1/stage-2 pipeline.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            vs_on_q  <= 1'b0;
            frame_ok <= 1'b0;
            mode_r   <= MODE_BYPASS;
            sync_d   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_mode  <= MODE_BYPASS;
            s1_ok    <= 1'b0;
            s1_fg    <= 1'b0;
            s1_pix   <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
            s2_mode  <= MODE_BYPASS;
            s2_ok    <= 1'b0;
            s2_pix   <= '0;
            win      <= '0;
        end else begin
            vs_on_q <= vs_on;
            sync_d  <= {sync_d[LAT-2:0], sync_in};

            if (!vid.iVGA_de)      col <= '0;
            else if (col != COL_SAT) col <= col + COL_W'(1);

            if (vs_edge)                                            row <= '0;
            else if (sync_d[0].de && !vid.iVGA_de && row != ROW_SAT) row <= row + ROW_W'(1);

            if (vs_edge) begin
                mode_r   <= vid.iMode;
                frame_ok <= 1'b1;
            end

            s1_col  <= col;
            s1_row  <= row;
            s1_mode <= eff_mode;
            s1_ok   <= frame_ok;
            s1_fg   <= (vid.iRGB_565 == FG_565);
            s1_pix  <= vid.iRGB_565;

            s2_col  <= s1_col;
            s2_row  <= s1_row;
            s2_mode <= s1_mode;
            s2_ok   <= s1_ok;
            s2_pix  <= s1_pix;
            win[0]  <= win[1];
            win[1]  <= win[2];
            win[2]  <= {rd2, rd1, s1_fg};
        end
    end

    logic [8:0]  win_bits;
    logic [3:0]  pop;
    logic        morph_fg, border;
    logic [15:0] pix_nx;

    // Stage 3 mode function, border forcing and blanking.
    always_comb begin
        win_bits = win;
        pop      = popcount9(win_bits);
        morph_fg = 1'b0;
        case (s2_mode)
            MODE_ERODE:    morph_fg = &win_bits;
            MODE_DILATE:   morph_fg = |win_bits;
            MODE_MAJORITY: morph_fg = (pop >= MAJ_THRESH);
            default:       morph_fg = 1'b0;
        endcase
        border = (s2_col < COL_W'(2)) | (s2_col >= COL_SAT) |
                 (s2_row < ROW_W'(2)) | ~s2_ok;
        if (!sync_d[1].de)                pix_nx = '0;
        else if (s2_mode == MODE_BYPASS)  pix_nx = s2_pix;
        else if (morph_fg && !border)     pix_nx = FG_565;
        else                              pix_nx = BG_565;
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) out_565 <= '0;
        else     out_565 <= pix_nx;
    end

    assign vid.oVGA_de  = sync_d[LAT-1].de;
    assign vid.oVGA_hs  = sync_d[LAT-1].hs;
    assign vid.oVGA_vs  = sync_d[LAT-1].vs;
    assign vid.oVGA_565 = out_565;

endmodule

// File: tb/tb_edge_morph.sv
// Randomized frame-level bench for edge_morph against an image-array reference model.
module tb_edge_morph;
    localparam int          HM = 48;
    localparam logic [15:0] FG = 16'h0000;
    localparam logic [15:0] BG = 16'hFFFF;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] pix;
    } exp_t;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;

    edge_morph_if vid();

    edge_morph #(.H_MAX(HM), .VS_ACTIVE(1'b1)) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .vid     (vid)
    );

    always #5 vga_clk = ~vga_clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    logic [15:0] img [0:31][0:63];
    logic [1:0]  cur_mode = 2'b00;
    logic [1:0]  mode_m   = 2'b00;
    bit          ok_m = 1'b0, vs_prev_m = 1'b0;
    bit          in_reset = 1'b1, ast_pending = 1'b0, rel_pending = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output pixel for input (x, y), computed straight from the frame image.
    function automatic logic [15:0] model_pix(input int x, input int y, input logic [1:0] m, input bit ok);
        int cnt;
        bit fg;
        if (m == 2'b00) return img[y][x];
        if (!ok || x < 2 || y < 2 || x >= HM) return BG;
        cnt = 0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (img[y-dy][x-dx] == FG) cnt++;
        case (m)
            2'b01:   fg = (cnt == 9);
            2'b10:   fg = (cnt > 0);
            default: fg = (cnt >= 5);
        endcase
        return fg ? FG : BG;
    endfunction

    task automatic drive_cycle(input bit de, input bit hs, input bit vs,
                               input logic [15:0] pix, input int x, input int y);
        exp_t e;
        @(posedge vga_clk);
        #1;
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check_eq("de",  32'(vid.oVGA_de),  32'(e.de));
            check_eq("hs",  32'(vid.oVGA_hs),  32'(e.hs));
            check_eq("vs",  32'(vid.oVGA_vs),  32'(e.vs));
            check_eq("pix", 32'(vid.oVGA_565), 32'(e.pix));
        end
        vid.iVGA_de  = de;
        vid.iVGA_hs  = hs;
        vid.iVGA_vs  = vs;
        vid.iRGB_565 = pix;
        vid.iMode    = cur_mode;
        if (rel_pending) begin
            #1 rst = 1'b0;
            in_reset    = 1'b0;
            rel_pending = 1'b0;
        end
        if (in_reset) begin
            e = '0;
        end else begin
            e.de  = de;
            e.hs  = hs;
            e.vs  = vs;
            e.pix = de ? model_pix(x, y, ok_m ? mode_m : cur_mode, ok_m) : 16'h0000;
            if (vs && !vs_prev_m) begin
                mode_m = cur_mode;
                ok_m   = 1'b1;
            end
            vs_prev_m = vs;
        end
        exp_q.push_back(e);
        if (ast_pending) begin
            #1 rst = 1'b1;
            #1;
            check_eq("rst_de",  32'(vid.oVGA_de),  32'd0);
            check_eq("rst_hs",  32'(vid.oVGA_hs),  32'd0);
            check_eq("rst_vs",  32'(vid.oVGA_vs),  32'd0);
            check_eq("rst_pix", 32'(vid.oVGA_565), 32'd0);
            foreach (exp_q[i]) exp_q[i] = '0;
            in_reset    = 1'b1;
            ast_pending = 1'b0;
            ok_m        = 1'b0;
            mode_m      = 2'b00;
            vs_prev_m   = 1'b0;
        end
    endtask

    // Patterns: 0 random fg density pct, 1 single fg at (10,10), 2 fg block 20..24, 3 all fg.
    task automatic fill_image(input int pat, input int pct);
        logic [15:0] v;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) begin
                v = 16'($urandom);
                if (v == FG) v = 16'h5A5A;
                case (pat)
                    0:       img[y][x] = (int'($urandom_range(99)) < pct) ? FG : v;
                    1:       img[y][x] = (x == 10 && y == 10) ? FG : v;
                    2:       img[y][x] = (x >= 20 && x <= 24 && y >= 20 && y <= 24) ? FG : v;
                    default: img[y][x] = FG;
                endcase
            end
    endtask

    task automatic drive_frame(input int w, input int h, input logic [1:0] mode,
                               input int sw_line, input logic [1:0] sw_mode, input int rst_line);
        int nb;
        cur_mode = mode;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
        for (int y = 0; y < h; y++) begin
            if (y == sw_line) cur_mode = sw_mode;
            nb = (y % 2 == 1) ? 1 : int'($urandom_range(4, 2));
            for (int i = 0; i < nb; i++) drive_cycle(1'b0, (i == 0 && nb > 1), 1'b0, 16'h0, 0, 0);
            for (int x = 0; x < w; x++) begin
                if (y == rst_line && x == 5) ast_pending = 1'b1;
                drive_cycle(1'b1, 1'b0, 1'b0, img[y][x], x, y);
            end
            if (y == rst_line) rel_pending = 1'b1;
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
    endtask

    initial begin
        vid.iMode    = 2'b00;
        vid.iVGA_de  = 1'b0;
        vid.iVGA_hs  = 1'b0;
        vid.iVGA_vs  = 1'b0;
        vid.iRGB_565 = 16'h0;
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
        rel_pending = 1'b1;

        fill_image(0, 30);  drive_frame(40, 32, 2'b00, -1, 2'b00, -1);
        fill_image(1, 0);   drive_frame(40, 32, 2'b10, -1, 2'b00, -1);
        fill_image(1, 0);   drive_frame(40, 32, 2'b01, -1, 2'b00, -1);
        fill_image(1, 0);   drive_frame(40, 32, 2'b11, -1, 2'b00, -1);
        fill_image(2, 0);   drive_frame(40, 32, 2'b01, -1, 2'b00, -1);
        fill_image(2, 0);   drive_frame(40, 32, 2'b10, -1, 2'b00, -1);
        fill_image(3, 0);   drive_frame(40, 32, 2'b01, -1, 2'b00, -1);
        fill_image(0, 50);  drive_frame(40, 32, 2'b11, -1, 2'b00, -1);
        fill_image(0, 80);  drive_frame(40, 32, 2'b01, 10, 2'b10, -1);
        fill_image(0, 20);  drive_frame(40, 32, 2'b10, -1, 2'b00, -1);
        fill_image(0, 20);  drive_frame(40, 32, 2'b10, -1, 2'b00, 12);
        fill_image(0, 20);  drive_frame(40, 32, 2'b10, -1, 2'b00, -1);
        fill_image(0, 50);  drive_frame(52, 32, 2'b11, -1, 2'b00, -1);
        fill_image(0, 40);  drive_frame(52, 32, 2'b00, -1, 2'b00, -1);

        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
